imm_pack_writer: RTL and testbench
==================================

Name: imm_pack_writer

Overview:
- Immediate encoder and instruction-memory writer: the inverse of the core's immediate extender.
- Takes a base instruction word and a 32-bit immediate value. Range-checks the immediate for the selected format, scatters its bits into the instruction's immediate fields, and writes the packed word to sequential instruction-memory addresses.
- Used by the test/boot program loader. Round-trip property: decoding a written word with the same imm_src/signed selection returns imm_i.

Parameters:
ADDR_WIDTH, 16, instruction-memory byte-address width; addresses advance by 4 and wrap modulo 2^ADDR_WIDTH.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  pulse; starts a load session (honoured in IDLE only)
start_addr_i  in  ADDR_WIDTH  first write address, must be word-aligned
valid_i  in  1  input word valid
ready_o  out  1  block can accept a word
last_i  in  1  marks the final word of the session (qualified by valid_i)
base_i  in  32  instruction with opcode/rd/funct/rs fields; its immediate bits are replaced
imm_i  in  32  immediate value to encode
imm_src_i  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 111 unsigned B, 110 illegal
signed_i  in  1  I-type only: 1 signed range, 0 unsigned range
wr_en_o  out  1  instruction-memory write strobe
wr_addr_o  out  ADDR_WIDTH  write byte address
wr_data_o  out  32  packed instruction word
done_o  out  1  one-cycle pulse: session finished
err_o  out  1  sticky: at least one word rejected this session
word_count_o  out  16  words written this session
err_count_o  out  8  words rejected this session, saturates at 255

Behaviour:
- Reset (all synchronous): FSM to IDLE. wr_en_o=0, wr_addr_o=0, wr_data_o=0, done_o=0, err_o=0, both counters 0. Any in-flight word is dropped.
- FSM states:
  - IDLE: ready_o=0 and valid_i is ignored. start_i loads the address register from start_addr_i, clears err_o and both counters, and moves to RUN.
  - RUN: ready_o=1 and start_i is ignored. An accept is valid_i&ready_o. An accept with last_i=1 moves to IDLE, so ready_o=0 in the next cycle.
- Pipeline: one register stage. A word accepted in cycle N produces its write/reject outcome in cycle N+1.
  - Accepted word in range: wr_en_o=1, wr_data_o=packed word, wr_addr_o=current address; address +4 after the write; word_count_o+1.
  - Out of range: wr_en_o=0, address unchanged, err_o set, err_count_o+1 (saturating).
  - Last word: done_o=1 in cycle N+1 whether that word was written or rejected.
- Back-to-back accepts every cycle are supported with no bubbles.
- Range rules (imm_i read as two's complement):
  - I, signed_i=1: -2048..2047. I, signed_i=0: 0..4095.
  - S: -2048..2047.
  - B: -4096..4094, bit0=0.
  - 111 (unsigned B): 0..8190, bit0=0.
  - U: imm_i[11:0]=0.
  - J: -1048576..1048574, bit0=0.
  - shamt: 0..31; signed_i is ignored.
  - 110: always rejected.
- Packing (instruction bits overwritten from imm bits; all other bits come from base_i):
  - I: [31:20]=imm[11:0].
  - shamt: [24:20]=imm[4:0]; [31:25] kept from base_i so the SRAI funct7 is preserved.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B / 111: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Address wrap: 0x...FFFC + 4 wraps to 0, with no error.
- Simultaneous events:
  - start_i in the same cycle as the last word's write (cycle N+1, FSM already IDLE): the write uses the old address, then the new session loads.
  - When the new session loads, the counters clear after the final increment has been applied.
- wr_data_o and wr_addr_o hold their last values when wr_en_o=0.

Test Plan:
- I-type: start_addr 0x0000, base 0x00000013, imm -1, signed_i=1, last=1 -> cycle N+1: wr_en=1, addr 0x0000, data 0xFFF00013, done_o=1, word_count=1.
- S then B, back-to-back: S base 0x00002023, imm 2047 -> 0x7E002FA3 @0x0000. Then B base 0x00000063, imm -4 -> 0xFE000EE3 @0x0004. Writes land on consecutive cycles.
- J and U: J base 0x6F, imm 8 -> 0x0080006F. U base 0x37, imm 0x12345000 -> 0x12345037. U imm 0x12345001 -> no write, err_o=1, err_count=1, next good word reuses the same address.
- Range edges: I signed imm 2048 rejected; I unsigned imm 4095 -> 0xFFF00013; B imm 3 rejected (odd); shamt 32 rejected; imm_src 110 rejected; each rejection adds 1 to err_count_o.
- Wrap: ADDR_WIDTH=16, start 0xFFFC, two valid words -> writes at 0xFFFC then 0x0000.
- Reset/control: rst_i asserted the cycle after an accept -> no write, all outputs 0, FSM IDLE. valid_i in IDLE is ignored. start_i during RUN is ignored, with address and counters unchanged.

Source files
------------

// File: rtl/imm_pack_writer.sv
// Immediate encoder and instruction-memory writer for the program loader.
// Range-checks an immediate, scatters it into a base instruction, writes it out.
module imm_pack_writer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  last_i,
    input  logic [31:0]           base_i,
    input  logic [31:0]           imm_i,
    input  logic [2:0]            imm_src_i,
    input  logic                  signed_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           word_count_o,
    output logic [7:0]            err_count_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  in_range;
    logic [31:0]           pack_word;
    logic                  fit_s12;
    logic                  fit_s13;
    logic                  fit_s21;

    assign ready_o = (state == RUN);
    assign accept  = valid_i & ready_o;

    // A value fits an N-bit signed field when all bits above N-2 match.
    assign fit_s12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fit_s13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fit_s21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        in_range  = 1'b0;
        pack_word = base_i;
        unique case (imm_src_i)
            3'b000: begin
                in_range = signed_i ? fit_s12 : ~(|imm_i[31:12]);
                pack_word[31:20] = imm_i[11:0];
            end
            3'b001: begin
                in_range = fit_s12;
                pack_word[31:25] = imm_i[11:5];
                pack_word[11:7]  = imm_i[4:0];
            end
            3'b010, 3'b111: begin
                if (imm_src_i == 3'b010)
                    in_range = fit_s13 & ~imm_i[0];
                else
                    in_range = ~(|imm_i[31:13]) & ~imm_i[0];
                pack_word[31]    = imm_i[12];
                pack_word[7]     = imm_i[11];
                pack_word[30:25] = imm_i[10:5];
                pack_word[11:8]  = imm_i[4:1];
            end
            3'b011: begin
                in_range = ~(|imm_i[11:0]);
                pack_word[31:12] = imm_i[31:12];
            end
            3'b100: begin
                in_range = fit_s21 & ~imm_i[0];
                pack_word[31]    = imm_i[20];
                pack_word[19:12] = imm_i[19:12];
                pack_word[20]    = imm_i[11];
                pack_word[30:21] = imm_i[10:1];
            end
            3'b101: begin
                // funct7 in [31:25] stays from base so SRAI survives
                in_range = ~(|imm_i[31:5]);
                pack_word[24:20] = imm_i[4:0];
            end
            3'b110: begin
                in_range = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            addr         <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            word_count_o <= '0;
            err_count_o  <= '0;
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        addr         <= {start_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        err_o        <= 1'b0;
                        word_count_o <= '0;
                        err_count_o  <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        done_o <= last_i;
                        if (last_i)
                            state <= IDLE;
                        if (in_range) begin
                            wr_en_o      <= 1'b1;
                            wr_data_o    <= pack_word;
                            wr_addr_o    <= addr;
                            addr         <= addr + ADDR_WIDTH'(4);
                            word_count_o <= word_count_o + 16'd1;
                        end else begin
                            err_o <= 1'b1;
                            if (err_count_o != 8'hFF)
                                err_count_o <= err_count_o + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_pack_writer.sv
// Directed bench for imm_pack_writer.
// Hand-computed packed words and addresses per scenario.
module tb_imm_pack_writer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] start_addr_i;
    logic        valid_i;
    logic        ready_o;
    logic        last_i;
    logic [31:0] base_i;
    logic [31:0] imm_i;
    logic [2:0]  imm_src_i;
    logic        signed_i;
    logic        wr_en_o;
    logic [15:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] word_count_o;
    logic [7:0]  err_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    imm_pack_writer #(.ADDR_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .last_i       (last_i),
        .base_i       (base_i),
        .imm_i        (imm_i),
        .imm_src_i    (imm_src_i),
        .signed_i     (signed_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_count_o (word_count_o),
        .err_count_o  (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [31:0] b, input logic [31:0] imm,
                       input logic [2:0] src, input logic sg,
                       input logic lst);
        valid_i   = 1'b1;
        base_i    = b;
        imm_i     = imm;
        imm_src_i = src;
        signed_i  = sg;
        last_i    = lst;
    endtask

    task automatic begin_session(input logic [15:0] a);
        valid_i      = 1'b0;
        start_i      = 1'b1;
        start_addr_i = a;
        tick();
        start_i = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [15:0] a,
                             input logic [31:0] d);
        check({tag, "_en"}, 32'(wr_en_o), 32'd1);
        check({tag, "_addr"}, 32'(wr_addr_o), 32'(a));
        check({tag, "_data"}, wr_data_o, d);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0;
        valid_i = 1'b0; last_i = 1'b0; base_i = '0;
        imm_i = '0; imm_src_i = '0; signed_i = 1'b0;
        repeat (2) tick();
        check("rst_en", 32'(wr_en_o), 0);
        check("rst_addr", 32'(wr_addr_o), 0);
        check("rst_data", wr_data_o, 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_wc", 32'(word_count_o), 0);
        check("rst_ec", 32'(err_count_o), 0);
        check("rst_ready", 32'(ready_o), 0);
        rst_i = 1'b0;
        tick();

        // single I-type word
        begin_session(16'h0000);
        check("run_ready", 32'(ready_o), 1);
        put(32'h13, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b1);
        tick();
        valid_i = 1'b0;
        chk_write("i_neg", 16'h0000, 32'hFFF0_0013);
        check("i_done", 32'(done_o), 1);
        check("i_wc", 32'(word_count_o), 1);
        tick();
        check("idle_ready", 32'(ready_o), 0);
        check("done_pulse", 32'(done_o), 0);

        // S then B back-to-back
        begin_session(16'h0000);
        check("wc_clear", 32'(word_count_o), 0);
        put(32'h2023, 32'h7FF, 3'b001, 1'b0, 1'b0);
        tick();
        chk_write("s", 16'h0000, 32'h7E00_2FA3);
        put(32'h63, 32'hFFFF_FFFC, 3'b010, 1'b0, 1'b1);
        tick();
        valid_i = 1'b0;
        chk_write("b", 16'h0004, 32'hFE00_0EE3);
        check("b_done", 32'(done_o), 1);
        check("b_wc", 32'(word_count_o), 2);

        // J, U, rejected U, then address reuse
        begin_session(16'h0100);
        put(32'h6F, 32'h8, 3'b100, 1'b0, 1'b0);
        tick();
        chk_write("j", 16'h0100, 32'h0080_006F);
        put(32'h37, 32'h1234_5000, 3'b011, 1'b0, 1'b0);
        tick();
        chk_write("u", 16'h0104, 32'h1234_5037);
        put(32'h37, 32'h1234_5001, 3'b011, 1'b0, 1'b0);
        tick();
        check("u_bad_en", 32'(wr_en_o), 0);
        check("u_bad_err", 32'(err_o), 1);
        check("u_bad_ec", 32'(err_count_o), 1);
        check("u_bad_hold", wr_data_o, 32'h1234_5037);
        put(32'h13, 32'h5, 3'b000, 1'b1, 1'b1);
        tick();
        valid_i = 1'b0;
        chk_write("reuse", 16'h0108, 32'h0050_0013);
        check("reuse_wc", 32'(word_count_o), 3);
        check("reuse_done", 32'(done_o), 1);

        // range edges
        begin_session(16'h0200);
        check("err_clear", 32'(err_o), 0);
        check("ec_clear", 32'(err_count_o), 0);
        put(32'h13, 32'h800, 3'b000, 1'b1, 1'b0);
        tick();
        check("i2048_en", 32'(wr_en_o), 0);
        check("i2048_ec", 32'(err_count_o), 1);
        put(32'h13, 32'hFFF, 3'b000, 1'b0, 1'b0);
        tick();
        chk_write("iu4095", 16'h0200, 32'hFFF0_0013);
        put(32'h63, 32'h1FFE, 3'b111, 1'b0, 1'b0);
        tick();
        chk_write("ub8190", 16'h0204, 32'hFE00_0FE3);
        put(32'h63, 32'h3, 3'b010, 1'b0, 1'b0);
        tick();
        check("bodd_en", 32'(wr_en_o), 0);
        check("bodd_ec", 32'(err_count_o), 2);
        put(32'h4000_5013, 32'h20, 3'b101, 1'b1, 1'b0);
        tick();
        check("sh32_en", 32'(wr_en_o), 0);
        check("sh32_ec", 32'(err_count_o), 3);
        put(32'h4000_5013, 32'h1F, 3'b101, 1'b1, 1'b0);
        tick();
        chk_write("sh31", 16'h0208, 32'h41F0_5013);
        valid_i = 1'b0;
        start_i = 1'b1;
        start_addr_i = 16'h0500;
        tick();
        start_i = 1'b0;
        check("ign_ready", 32'(ready_o), 1);
        check("ign_wc", 32'(word_count_o), 3);
        check("ign_ec", 32'(err_count_o), 3);
        put(32'h13, 32'h1, 3'b000, 1'b1, 1'b0);
        tick();
        chk_write("ign_addr", 16'h020C, 32'h0010_0013);
        put(32'h2023, 32'hFFFF_F800, 3'b001, 1'b0, 1'b0);
        tick();
        chk_write("s_min", 16'h0210, 32'h8000_2023);
        put(32'h13, 32'h0, 3'b110, 1'b0, 1'b1);
        tick();
        valid_i = 1'b0;
        check("ill_en", 32'(wr_en_o), 0);
        check("ill_ec", 32'(err_count_o), 4);
        check("ill_done", 32'(done_o), 1);
        check("ill_err", 32'(err_o), 1);
        check("ill_wc", 32'(word_count_o), 5);

        // valid while idle
        tick();
        put(32'h13, 32'h1, 3'b000, 1'b1, 1'b0);
        tick();
        valid_i = 1'b0;
        check("idle_en", 32'(wr_en_o), 0);
        check("idle_wc", 32'(word_count_o), 5);

        // address wrap
        begin_session(16'hFFFC);
        put(32'h13, 32'h2, 3'b000, 1'b1, 1'b0);
        tick();
        chk_write("wrap0", 16'hFFFC, 32'h0020_0013);
        put(32'h13, 32'h3, 3'b000, 1'b1, 1'b1);
        tick();
        valid_i = 1'b0;
        chk_write("wrap1", 16'h0000, 32'h0030_0013);

        // start in the cycle of the last write
        begin_session(16'h0300);
        put(32'h13, 32'h7, 3'b000, 1'b1, 1'b1);
        tick();
        valid_i = 1'b0;
        chk_write("ovl", 16'h0300, 32'h0070_0013);
        check("ovl_wc", 32'(word_count_o), 1);
        start_i = 1'b1;
        start_addr_i = 16'h0400;
        tick();
        start_i = 1'b0;
        check("ovl_clr", 32'(word_count_o), 0);
        check("ovl_ready", 32'(ready_o), 1);
        put(32'h13, 32'h9, 3'b000, 1'b1, 1'b1);
        tick();
        valid_i = 1'b0;
        chk_write("ovl_new", 16'h0400, 32'h0090_0013);

        // reset drops an in-flight word
        begin_session(16'h0010);
        put(32'h13, 32'h1, 3'b000, 1'b1, 1'b0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        valid_i = 1'b0;
        check("mrst_en", 32'(wr_en_o), 0);
        check("mrst_addr", 32'(wr_addr_o), 0);
        check("mrst_data", wr_data_o, 0);
        check("mrst_wc", 32'(word_count_o), 0);
        check("mrst_ready", 32'(ready_o), 0);
        tick();
        check("mrst_idle", 32'(ready_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
